// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master frame engine: FSM state encoding
// and the idle levels of the serial clock and chip select pins.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  localparam logic SCLK_IDLE   = 1'b0;
  localparam logic CS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI master: counts CLK_DIV enabled cycles per
// sclk half-period and flags whether the period that just ended was low (rise) or high (fall).
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] count;
  logic          phase;
  logic          tick;

  // phase is 0 while sclk is low, so the tick that ends a low half-period is a rise
  assign tick      = enable && (count == CW'(CLK_DIV - 1));
  assign rise_tick = tick && !phase;
  assign fall_tick = tick && phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      count <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      count <= '0;
      phase <= ~phase;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master frame engine: one word per valid/ready accept, full-duplex shift.
// Define SPI_LSB_FIRST_EN to shift LSB first; the default build is MSB first.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int DATA_W  = 5,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              load_bit;
  logic              next_bit;
  logic              div_en;
  logic              div_clr;
  logic              rise_tick;
  logic              fall_tick;
  logic              tick;

  // tx_shift rotates so the register stays fully used; only the bit on mosi matters
`ifdef SPI_LSB_FIRST_EN
  assign load_bit = tx_data[0];
  assign tx_next  = {tx_shift[0], tx_shift[DATA_W-1:1]};
  assign next_bit = tx_next[0];
  assign rx_next  = {miso, rx_shift[DATA_W-1:1]};
`else
  assign load_bit = tx_data[DATA_W-1];
  assign tx_next  = {tx_shift[DATA_W-2:0], tx_shift[DATA_W-1]};
  assign next_bit = tx_next[DATA_W-1];
  assign rx_next  = {rx_shift[DATA_W-2:0], miso};
`endif

  assign tick    = rise_tick | fall_tick;
  assign div_en  = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign div_clr = !div_en || ((state != XFER) && tick);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (div_en),
    .clear    (div_clr),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cs_n     <= CS_INACTIVE;
      sclk     <= SCLK_IDLE;
      mosi     <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state    <= SETUP;
            tx_shift <= tx_data;
            rx_shift <= '0;
            mosi     <= load_bit;
            cs_n     <= ~CS_INACTIVE;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (rise_tick) begin
            sclk     <= ~SCLK_IDLE;
            rx_shift <= rx_next;
          end else if (fall_tick) begin
            sclk    <= SCLK_IDLE;
            bit_cnt <= bit_cnt + BW'(1);
            // the last falling edge closes the frame without advancing mosi
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= HOLD;
            end else begin
              tx_shift <= tx_next;
              mosi     <= next_bit;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state    <= GAP;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            cs_n     <= CS_INACTIVE;
            mosi     <= 1'b0;
            gap_cnt  <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Self-checking bench for spi_master_xfer: a cycle-position model of the frame
// checked every cycle, plus directed frames with hand-computed literal results.
`timescale 1ns/1ps
module tb_spi_master_xfer;

  localparam int DATA_W    = 5;
  localparam int CLK_DIV   = 4;
  localparam int CS_GAP    = 2;
  localparam int FRAME_END = (2 * DATA_W + 2) * CLK_DIV;
  localparam int IDLE_AT   = FRAME_END + CS_GAP;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              loopback = 1'b1;
  logic              miso_level = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign miso = loopback ? mosi : miso_level;

  always #5 clk = ~clk;

  spi_master_xfer #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Transmission order j (0 = first on the wire) mapped to the word bit index
  function automatic int bit_pos(input int j);
`ifdef SPI_LSB_FIRST_EN
    return j;
`else
    return DATA_W - 1 - j;
`endif
  endfunction

  function automatic logic is_rise(input int k);
    return (k % (2 * CLK_DIV) == 0) && (k >= 2 * CLK_DIV) && (k <= 2 * CLK_DIV * DATA_W);
  endfunction

  function automatic int rise_idx(input int k);
    return k / (2 * CLK_DIV) - 1;
  endfunction

  function automatic logic exp_sclk(input int k);
    return (k >= 2 * CLK_DIV) && (k < FRAME_END) && ((k / CLK_DIV) % 2 == 0);
  endfunction

  function automatic logic exp_mosi(input int k, input logic [DATA_W-1:0] word);
    int j;
    if (k >= FRAME_END) return 1'b0;
    j = (k < 3 * CLK_DIV) ? 0 : (k - CLK_DIV) / (2 * CLK_DIV);
    if (j > DATA_W - 1) j = DATA_W - 1;
    return word[bit_pos(j)];
  endfunction

  // Model: m_k counts clock edges since the accepting edge of the current frame
  logic              m_active;
  int                m_k;
  logic [DATA_W-1:0] m_word;
  logic [DATA_W-1:0] m_bits;
  logic [DATA_W-1:0] m_rx;
  logic              m_idle;

  assign m_idle = !m_active || (m_k >= IDLE_AT);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_word   <= '0;
      m_bits   <= '0;
      m_rx     <= '0;
    end else if (m_idle) begin
      if (tx_valid) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_word   <= tx_data;
        m_bits   <= '0;
      end
    end else begin
      m_k <= m_k + 1;
      if (is_rise(m_k + 1)) m_bits[bit_pos(rise_idx(m_k + 1))] <= miso;
      if (m_k + 1 == FRAME_END) m_rx <= m_bits;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("tx_ready", tx_ready, m_idle);
      checkOutput("busy", busy, !m_idle);
      checkOutput("cs_n", cs_n, m_idle || (m_k >= FRAME_END));
      checkOutput("sclk", sclk, m_idle ? 1'b0 : exp_sclk(m_k));
      checkOutput("mosi", mosi, m_idle ? 1'b0 : exp_mosi(m_k, m_word));
      checkOutput("rx_valid", rx_valid, !m_idle && (m_k == FRAME_END));
      checkOutput("rx_data", rx_data, m_rx);
    end
  end

  task automatic waitIdle();
    int i;
    i = 0;
    while (!tx_ready && i < 500) begin
      @(negedge clk);
      i++;
    end
    checkOutput("wait_idle", tx_ready, 1'b1);
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] word, input logic lb, input logic lvl,
                               output int latency, output logic [DATA_W-1:0] seq,
                               output int pulses, output int hi_min, output int hi_max);
    int   run;
    logic prev;
    waitIdle();
    @(negedge clk);
    loopback   = lb;
    miso_level = lvl;
    tx_data    = word;
    tx_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    latency  = 0;
    seq      = '0;
    pulses   = 0;
    hi_min   = 1000;
    hi_max   = 0;
    run      = 0;
    prev     = 1'b0;
    while (!rx_valid && latency < 200) begin
      if (sclk && !prev) begin
        seq = {seq[DATA_W-2:0], mosi};
        pulses++;
      end
      if (sclk) begin
        run++;
      end else if (prev) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
      end
      prev = sclk;
      @(negedge clk);
      latency++;
    end
  endtask

  int   falls;
  int   valids;
  int   gap_run;
  int   gap_min;
  logic prev_cs;

  task automatic observeFrames();
    if (prev_cs && !cs_n) begin
      if (falls > 0 && gap_run < gap_min) gap_min = gap_run;
      falls++;
    end
    if (cs_n) gap_run++;
    else gap_run = 0;
    if (rx_valid) valids++;
    prev_cs = cs_n;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int                lat;
    int                pulses;
    int                hi_min;
    int                hi_max;
    int                stray;
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] seq_10110;
    logic              first_00001;

`ifdef SPI_LSB_FIRST_EN
    seq_10110   = 5'b01101;
    first_00001 = 1'b1;
`else
    seq_10110   = 5'b10110;
    first_00001 = 1'b0;
`endif

    // Reset, then the idle levels
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_cs_n", cs_n, 1'b1);
    checkOutput("rst_sclk", sclk, 1'b0);
    checkOutput("rst_mosi", mosi, 1'b0);
    checkOutput("rst_tx_ready", tx_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_data", rx_data, 5'b00000);

    // Loopback 10110
    applyStimulus(5'b10110, 1'b1, 1'b0, lat, seq, pulses, hi_min, hi_max);
    checkOutput("lb_latency", lat, 48);
    checkOutput("lb_rx_data", rx_data, 5'b10110);
    checkOutput("lb_mosi_seq", seq, seq_10110);
    checkOutput("lb_pulses", pulses, 5);
    @(negedge clk);
    checkOutput("lb_rx_valid_once", rx_valid, 1'b0);

    // miso held high, all-zero word
    applyStimulus(5'b00000, 1'b0, 1'b1, lat, seq, pulses, hi_min, hi_max);
    checkOutput("ones_latency", lat, 48);
    checkOutput("ones_rx_data", rx_data, 5'b11111);
    checkOutput("ones_hi_min", hi_min, 4);
    checkOutput("ones_hi_max", hi_max, 4);
    checkOutput("ones_pulses", pulses, 5);

    // tx_valid held for 200 cycles with changing data
    waitIdle();
    loopback = 1'b1;
    falls    = 0;
    valids   = 0;
    gap_run  = 0;
    gap_min  = 1000;
    prev_cs  = cs_n;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tx_data  = DATA_W'(i * 7 + 3);
      tx_valid = 1'b1;
      observeFrames();
    end
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      observeFrames();
      @(negedge clk);
    end
    checkOutput("stream_frames", falls, 4);
    checkOutput("stream_rx_valids", valids, 4);
    checkOutput("stream_gap_ge2", gap_min >= CS_GAP, 1'b1);

    // Reset in the middle of XFER, while sclk is high
    waitIdle();
    @(negedge clk);
    loopback = 1'b1;
    tx_data  = 5'b11011;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("mid_sclk_high", sclk, 1'b1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_cs_n", cs_n, 1'b1);
    checkOutput("mid_rst_sclk", sclk, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_tx_ready", tx_ready, 1'b1);
    checkOutput("mid_rst_rx_data", rx_data, 5'b00000);
    @(negedge clk);
    #2 reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) stray++;
    end
    checkOutput("mid_no_rx_valid", stray, 0);
    applyStimulus(5'b01101, 1'b1, 1'b0, lat, seq, pulses, hi_min, hi_max);
    checkOutput("post_rst_latency", lat, 48);
    checkOutput("post_rst_rx_data", rx_data, 5'b01101);
    checkOutput("post_rst_pulses", pulses, 5);

    // Loopback 00001: first bit on the wire depends on the bit order
    applyStimulus(5'b00001, 1'b1, 1'b0, lat, seq, pulses, hi_min, hi_max);
    checkOutput("one_first_bit", seq[DATA_W-1], first_00001);
    checkOutput("one_rx_data", rx_data, 5'b00001);
    checkOutput("one_latency", lat, 48);

    waitIdle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
